// File: rtl/chebyshev_openmp_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : chebyshev_openmp_mac_pipe
// Purpose  : Pipelined multiplier with optional saturating accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module chebyshev_openmp_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 32,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_valid,
    output logic                  ovf
);

    localparam int c_PROD_W = din0_WIDTH + din1_WIDTH;
    // Two guard bits above the wider operand keep the sum free of wrap-around.
    localparam int c_SW = ((c_PROD_W > dout_WIDTH) ? c_PROD_W : dout_WIDTH) + 2;
    localparam logic [c_SW-1:0] c_ONE = {{(c_SW-1){1'b0}}, 1'b1};
    localparam logic [c_SW-1:0] c_MAX = (SIGNED != 0) ? (c_ONE << (dout_WIDTH-1)) - c_ONE
                                                      : (c_ONE << dout_WIDTH) - c_ONE;
    localparam logic [c_SW-1:0] c_MIN = (SIGNED != 0) ? ~((c_ONE << (dout_WIDTH-1)) - c_ONE)
                                                      : {c_SW{1'b0}};

    logic                w_s0, w_s1;
    logic [c_PROD_W-1:0] w_ext0, w_ext1, w_prod;

    assign w_s0   = (SIGNED != 0) & din0[din0_WIDTH-1];
    assign w_s1   = (SIGNED != 0) & din1[din1_WIDTH-1];
    assign w_ext0 = {{(c_PROD_W-din0_WIDTH){w_s0}}, din0};
    assign w_ext1 = {{(c_PROD_W-din1_WIDTH){w_s1}}, din1};
    assign w_prod = w_ext0 * w_ext1;

    logic [c_PROD_W-1:0] w_f_prod;
    logic                w_f_vld, w_f_en, w_f_clr;

    if (NUM_STAGE > 1) begin : g_pipe
        localparam int c_D = NUM_STAGE - 1;
        logic [c_PROD_W-1:0] r_prod [c_D];
        logic [c_D-1:0]      r_vld, r_en, r_clr;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld <= '0;
            end else if (ce) begin
                r_vld[0]  <= in_valid;
                r_en[0]   <= acc_en;
                r_clr[0]  <= acc_clr;
                r_prod[0] <= w_prod;
                for (int i = 1; i < c_D; i++) begin
                    r_vld[i]  <= r_vld[i-1];
                    r_en[i]   <= r_en[i-1];
                    r_clr[i]  <= r_clr[i-1];
                    r_prod[i] <= r_prod[i-1];
                end
            end
        end

        assign w_f_prod = r_prod[c_D-1];
        assign w_f_vld  = r_vld[c_D-1];
        assign w_f_en   = r_en[c_D-1];
        assign w_f_clr  = r_clr[c_D-1];
    end else begin : g_direct
        assign w_f_prod = w_prod;
        assign w_f_vld  = in_valid;
        assign w_f_en   = acc_en;
        assign w_f_clr  = acc_clr;
    end

    logic [dout_WIDTH-1:0] r_acc;
    logic [c_SW-1:0]       w_pext, w_aext, w_sum;
    logic                  w_hi, w_lo, w_sat;
    logic [dout_WIDTH-1:0] w_acc_nxt;

    assign w_pext = {{(c_SW-c_PROD_W){(SIGNED != 0) & w_f_prod[c_PROD_W-1]}}, w_f_prod};
    assign w_aext = {{(c_SW-dout_WIDTH){(SIGNED != 0) & r_acc[dout_WIDTH-1]}}, r_acc};
    // A clear starts from zero so the product alone is range-checked.
    assign w_sum  = (w_f_clr ? {c_SW{1'b0}} : w_aext) + w_pext;
    assign w_hi   = $signed(w_sum) > $signed(c_MAX);
    assign w_lo   = $signed(w_sum) < $signed(c_MIN);
    assign w_sat  = w_hi | w_lo;
    assign w_acc_nxt = w_hi ? c_MAX[dout_WIDTH-1:0] :
                       w_lo ? c_MIN[dout_WIDTH-1:0] : w_sum[dout_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= w_f_vld;
            if (w_f_vld) begin
                if (w_f_en) begin
                    r_acc <= w_acc_nxt;
                    dout  <= w_acc_nxt;
                    ovf   <= (w_f_clr ? 1'b0 : ovf) | w_sat;
                end else begin
                    dout  <= w_pext[dout_WIDTH-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chebyshev_openmp_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_chebyshev_openmp_mac_pipe
// Purpose  : Directed bench with a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chebyshev_openmp_mac_pipe;

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, acc_en, acc_clr;
    logic [15:0] din0, din1;
    logic [31:0] dout_s, dout_u;
    logic        out_valid_s, out_valid_u, ovf_s, ovf_u;

    always #5 clk = ~clk;

    chebyshev_openmp_mac_pipe #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(16),
                                .dout_WIDTH(32), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .dout(dout_s), .out_valid(out_valid_s), .ovf(ovf_s));

    chebyshev_openmp_mac_pipe #(.ID(2), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(16),
                                .dout_WIDTH(32), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .dout(dout_u), .out_valid(out_valid_u), .ovf(ovf_u));

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else pass_cnt++;
    endtask

    // Reference model: results computed at acceptance, delivered after latency.
    typedef struct {
        logic [31:0] d0, d1;
        bit          o0, o1;
        int          rem;
    } ent_t;

    ent_t        q[$];
    longint      macc [2];
    bit          movf [2];
    logic [31:0] exp_d0, exp_d1;
    bit          exp_o0, exp_o1, exp_v, started = 0;

    function automatic longint prod_of(input bit sg, input logic [15:0] a, input logic [15:0] b);
        if (sg) return longint'($signed(a)) * longint'($signed(b));
        return longint'({48'd0, a}) * longint'({48'd0, b});
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            exp_v = 0; exp_d0 = 0; exp_d1 = 0; exp_o0 = 0; exp_o1 = 0;
            macc[0] = 0; macc[1] = 0; movf[0] = 0; movf[1] = 0;
            started = 1;
        end else if (ce) begin
            if (in_valid) begin
                ent_t e;
                e.rem = 3;
                for (int k = 0; k < 2; k++) begin
                    longint p, hi, lo, s, res;
                    bit sat;
                    p  = prod_of(k == 0, din0, din1);
                    hi = (k == 0) ? 64'sd2147483647 : 64'sd4294967295;
                    lo = (k == 0) ? -64'sd2147483648 : 64'sd0;
                    if (!acc_en) begin
                        res = p;
                    end else begin
                        s   = (acc_clr ? 64'sd0 : macc[k]) + p;
                        sat = (s > hi) || (s < lo);
                        if (s > hi) s = hi;
                        else if (s < lo) s = lo;
                        macc[k] = s;
                        movf[k] = acc_clr ? sat : (movf[k] | sat);
                        res = s;
                    end
                    if (k == 0) begin e.d0 = 32'(res); e.o0 = movf[0]; end
                    else        begin e.d1 = 32'(res); e.o1 = movf[1]; end
                end
                q.push_back(e);
            end
            foreach (q[i]) q[i].rem--;
            exp_v = 0;
            if (q.size() > 0 && q[0].rem == 0) begin
                exp_v  = 1;
                exp_d0 = q[0].d0; exp_d1 = q[0].d1;
                exp_o0 = q[0].o0; exp_o1 = q[0].o1;
                void'(q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("valid_s", out_valid_s, exp_v);
            chk("dout_s",  dout_s,      exp_d0);
            chk("ovf_s",   ovf_s,       exp_o0);
            chk("valid_u", out_valid_u, exp_v);
            chk("dout_u",  dout_u,      exp_d1);
            chk("ovf_u",   ovf_u,       exp_o1);
        end
    end

    logic [31:0] log_s[$], log_u[$];
    bit          log_o[$];

    always @(negedge clk) begin
        if (out_valid_s) begin log_s.push_back(dout_s); log_o.push_back(ovf_s); end
        if (out_valid_u) log_u.push_back(dout_u);
    end

    task automatic put(input bit v, input logic [15:0] a, input logic [15:0] b,
                       input bit en, input bit clr);
        @(negedge clk);
        in_valid = v; din0 = a; din1 = b; acc_en = en; acc_clr = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) put(0, 16'd0, 16'd0, 0, 0);
    endtask

    task automatic one(input logic [15:0] a, input logic [15:0] b, input bit en,
                       input bit clr, output int lat);
        put(1, a, b, en, clr);
        put(0, 16'd0, 16'd0, 0, 0);
        lat = 1;
        while (!out_valid_s && lat < 20) begin @(negedge clk); lat++; end
    endtask

    task automatic clear_logs();
        log_s.delete(); log_u.delete(); log_o.delete();
    endtask

    task automatic check_log(input string nm, input bit uns,
                             input logic [31:0] ed [4], input bit eo [4]);
        int n;
        n = uns ? log_u.size() : log_s.size();
        chk({nm, "_count"}, n, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                chk($sformatf("%s_d%0d", nm, i), uns ? log_u[i] : log_s[i], ed[i]);
                if (!uns) chk($sformatf("%s_o%0d", nm, i), log_o[i], eo[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        reset = 1; ce = 1; in_valid = 0; din0 = 0; din1 = 0; acc_en = 0; acc_clr = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid_s, 0);
        chk("rst_dout",  dout_s, 0);
        chk("rst_ovf",   ovf_s, 0);
        reset = 0;

        one(16'hFFFD, 16'd7, 0, 0, lat);
        chk("mul_lat", lat, 3);
        chk("mul_neg", dout_s, 32'hFFFFFFEB);
        @(negedge clk);
        chk("single_pulse", out_valid_s, 0);

        one(16'h8000, 16'h8000, 0, 0, lat);
        chk("min_sq_s", dout_s, 32'h40000000);
        one(16'hFFFF, 16'hFFFF, 0, 0, lat);
        chk("ffff_s", dout_s, 32'h00000001);
        chk("ffff_u", dout_u, 32'hFFFE0001);

        // Accept, then stall for two edges.
        put(1, 16'd5, 16'd6, 0, 0);
        @(negedge clk); in_valid = 0; ce = 0;
        lat = 1;
        while (!out_valid_s && lat < 20) begin
            @(negedge clk); lat++;
            if (lat == 3) ce = 1;
        end
        chk("stall_lat", lat, 5);
        chk("stall_dout", dout_s, 32'd30);
        ce = 0;
        repeat (2) @(negedge clk);
        chk("hold_valid", out_valid_s, 1);
        chk("hold_dout", dout_s, 32'd30);
        ce = 1;
        idle(2);

        clear_logs();
        put(1, 16'd1000, 16'd1000, 1, 1);
        repeat (3) put(1, 16'd1000, 16'd1000, 1, 0);
        idle(6);
        check_log("burst", 0, '{32'd1000000, 32'd2000000, 32'd3000000, 32'd4000000},
                  '{1'b0, 1'b0, 1'b0, 1'b0});

        clear_logs();
        put(1, 16'd10, 16'd10, 1, 1);
        put(1, 16'd5, 16'd5, 0, 0);
        put(1, 16'd3, 16'd3, 1, 0);
        put(0, 16'd9, 16'd9, 1, 1);
        put(1, 16'd1, 16'd1, 1, 0);
        idle(6);
        check_log("interleave", 0, '{32'd100, 32'd25, 32'd109, 32'd110},
                  '{1'b0, 1'b0, 1'b0, 1'b0});

        clear_logs();
        put(1, 16'h8000, 16'h7FFF, 1, 1);
        repeat (2) put(1, 16'h8000, 16'h7FFF, 1, 0);
        put(1, 16'd2, 16'd2, 1, 1);
        idle(6);
        check_log("negsat", 0, '{32'hC0008000, 32'h80010000, 32'h80000000, 32'd4},
                  '{1'b0, 1'b0, 1'b1, 1'b0});

        clear_logs();
        put(1, 16'h7FFF, 16'h7FFF, 1, 1);
        repeat (2) put(1, 16'h7FFF, 16'h7FFF, 1, 0);
        put(1, 16'd1, 16'd1, 1, 1);
        idle(6);
        check_log("possat", 0, '{32'h3FFF0001, 32'h7FFE0002, 32'h7FFFFFFF, 32'd1},
                  '{1'b0, 1'b0, 1'b1, 1'b0});
        check_log("possat_u", 1, '{32'h3FFF0001, 32'h7FFE0002, 32'hBFFD0003, 32'd1},
                  '{1'b0, 1'b0, 1'b0, 1'b0});

        // Set ovf, then reset with work in flight and a stalled clock enable.
        put(1, 16'h7FFF, 16'h7FFF, 1, 1);
        repeat (2) put(1, 16'h7FFF, 16'h7FFF, 1, 0);
        idle(6);
        chk("ovf_set", ovf_s, 1);
        clear_logs();
        put(1, 16'd3, 16'd3, 1, 0);
        put(1, 16'd4, 16'd4, 0, 0);
        @(negedge clk); reset = 1; ce = 0; in_valid = 1; din0 = 16'd7; din1 = 16'd7;
        @(negedge clk); reset = 0; ce = 1; in_valid = 0;
        chk("flush_valid", out_valid_s, 0);
        chk("flush_dout",  dout_s, 0);
        chk("flush_ovf",   ovf_s, 0);
        idle(6);
        chk("flush_none", log_s.size(), 0);

        one(16'd2, 16'd3, 0, 0, lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_dout", dout_s, 32'd6);
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chebyshev_openmp_mac_pipe.md
CHEBYSHEV_OPENMP_MAC_PIPE -- requirements
Module: chebyshev_openmp_mac_pipe

Interface
REQ-001 Parameter: ID, 1, instance tag; no functional effect.
REQ-002 Parameter: NUM_STAGE, 3, input-to-output latency in cycles; legal range 1..8.
REQ-003 Parameter: din0_WIDTH, 16, width of operand 0.
REQ-004 Parameter: din1_WIDTH, 16, width of operand 1.
REQ-005 Parameter: dout_WIDTH, 32, width of result and accumulator; legal range 2..64.
REQ-006 Parameter: SIGNED, 1, 1 = two's-complement operands and result, 0 = unsigned.
REQ-007 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-008 Port: reset, input, 1, reset; synchronous, active-high.
REQ-009 Port: ce, input, 1, clock enable; 0 freezes all internal state and outputs.
REQ-010 Port: in_valid, input, 1, din0/din1/acc_en/acc_clr are valid this cycle.
REQ-011 Port: din0, input, din0_WIDTH, operand 0.
REQ-012 Port: din1, input, din1_WIDTH, operand 1.
REQ-013 Port: acc_en, input, 1, 1 = accumulate the product; 0 = plain multiply.
REQ-014 Port: acc_clr, input, 1, with acc_en=1, starts a new sum (accumulator = this product).
REQ-015 Port: dout, output, dout_WIDTH, product or running sum.
REQ-016 Port: out_valid, output, 1, dout is valid this cycle.
REQ-017 Port: ovf, output, 1, sticky accumulator saturation flag.

Function
REQ-018 An input SHALL be accepted on a rising edge with ce=1 and in_valid=1; acc_en and acc_clr SHALL be captured together with the operands.
REQ-019 The full product SHALL be computed at width din0_WIDTH+din1_WIDTH, signed or unsigned per SIGNED.
REQ-020 The result of an accepted input SHALL appear on dout with out_valid=1 exactly NUM_STAGE ce=1 edges after acceptance; each accepted input SHALL yield exactly one out_valid pulse.
REQ-021 One input per cycle SHALL be accepted, with no bubbles inserted; in_valid=0 SHALL propagate as a bubble with out_valid=0.
REQ-022 With ce=0, pipeline registers, accumulator, dout, out_valid and ovf SHALL hold their values.
REQ-023 With acc_en=0, dout SHALL be the product sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to dout_WIDTH, or truncated to its low dout_WIDTH bits when narrower; the accumulator and ovf SHALL not change.
REQ-024 With acc_en=1 and acc_clr=1, the accumulator SHALL load the product, saturated to dout_WIDTH; ovf SHALL clear and then be set if this load saturates.
REQ-025 With acc_en=1 and acc_clr=0, the accumulator SHALL load the saturating sum accumulator+product.
REQ-026 Saturation bounds: SIGNED=1 -> [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]; SIGNED=0 -> [0, 2^dout_WIDTH-1].
REQ-027 Any saturation event SHALL set ovf; ovf SHALL remain set until reset or an acc_clr operation.
REQ-028 In accumulate mode, dout SHALL present the updated accumulator value.
REQ-029 Accumulator updates SHALL occur only in the final stage, on valid data; bubbles SHALL not modify the accumulator, and acc_clr on a bubble SHALL be ignored.
REQ-030 Back-to-back accumulate inputs SHALL each be summed exactly once, with no loss at full throughput.
REQ-031 Multiply results interleaved between accumulate inputs SHALL leave the accumulator intact.

Reset
REQ-032 With reset=1 at a rising edge, the block SHALL clear all pipeline valid bits, the accumulator, dout, out_valid and ovf to 0, regardless of ce.
REQ-033 Inputs present in the cycle reset is asserted SHALL be discarded; data in flight when reset is asserted SHALL never produce out_valid.
REQ-034 The first input SHALL be accepted on the first edge with reset=0, ce=1 and in_valid=1.

Verification (defaults: NUM_STAGE=3, 16x16->32, SIGNED=1)
REQ-035 din0=-3, din1=7, acc_en=0, accepted at cycle 0 -> out_valid=1 only at cycle 3, dout=0xFFFFFFEB.
REQ-036 din0=din1=-32768, acc_en=0 -> dout=0x40000000; with SIGNED=0 and operands 0xFFFF, 0xFFFF -> dout=0xFFFE0001.
REQ-037 Accept at cycle 0, then ce=0 during cycles 1-2 -> out_valid rises at cycle 5; dout and out_valid are held during the stall.
REQ-038 Four consecutive inputs of 1000*1000, acc_en=1, acc_clr=1 on the first only -> dout values 1000000, 2000000, 3000000, 4000000 on consecutive cycles; ovf=0.
REQ-039 Three accumulate inputs of 32767*32767 (1073676289 each), starting with acc_clr -> third dout=0x7FFFFFFF, ovf=1; a following acc_clr input of 1*1 -> dout=1, ovf=0.
REQ-040 Three inputs in flight, reset=1 for one cycle -> out_valid=0, dout=0, ovf=0 the next cycle; none of the three ever emerges.
